// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 digest output path.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Word k of a packed digest; H0 sits in the most significant word.
    function automatic logic [WORD_W-1:0] digest_word(
        input logic [NUM_WORDS*WORD_W-1:0] digest,
        input int                          k
    );
        return digest[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/sha256_digest_tx.sv
// Captures a 256-bit SHA-256 digest in one cycle and streams it out as eight
// 32-bit words (H0 first) on a valid/ready interface with backpressure.
module sha256_digest_tx
    import sha256_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        load,
    input  logic [NUM_WORDS*WORD_W-1:0] digest_i,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_last,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        done,
    output logic                        load_drop
);

    tx_state_t          state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               done_reg, done_next;
    logic               drop_reg, drop_next;
    logic               capture;
    logic               xfer;
    logic               at_last;
    logic [WORD_W-1:0]  word_reg [NUM_WORDS];

    assign xfer    = (state_reg == SEND) && out_ready;
    assign at_last = (idx_reg == IDX_W'(NUM_WORDS-1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        drop_next  = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer && at_last) begin
                    // Final word leaves: a load arriving now chains straight on.
                    done_next = 1'b1;
                    idx_next  = '0;
                    if (load) begin
                        capture = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                    drop_next = load;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Parallel capture so every word lands in the same cycle as the strobe.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                word_reg[gi] <= '0;
            end else if (capture) begin
                word_reg[gi] <= digest_word(digest_i, gi);
            end
        end
    end

    // Indexed select keeps out_data stable while the sink stalls.
    assign busy      = (state_reg == SEND);
    assign out_valid = (state_reg == SEND);
    assign out_data  = out_valid ? word_reg[idx_reg] : '0;
    assign out_idx   = out_valid ? idx_reg : '0;
    assign out_last  = out_valid && at_last;
    assign done      = done_reg;
    assign load_drop = drop_reg;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Self-checking bench for sha256_digest_tx: table-driven basic stream, directed
// corner sequences and randomized traffic against a queue-based stream model.
module tb_sha256_digest_tx;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         load = 1'b0;
    logic [255:0] digest_i = '0;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic [2:0]   out_idx;
    logic         done;
    logic         load_drop;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] DIG_A =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_B =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_F = {256{1'b1}};

    sha256_digest_tx dut (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .digest_i  (digest_i),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .done      (done),
        .load_drop (load_drop)
    );

    always #5 CLK = ~CLK;

    // Reference model: the stream still owed to the sink, one entry per word.
    typedef struct {
        logic [31:0] data;
        logic [2:0]  idx;
    } word_t;

    word_t q[$];
    logic  exp_done = 1'b0;
    logic  exp_drop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  ei;
        ev = (q.size() > 0);
        ed = ev ? q[0].data : 32'h0;
        ei = ev ? q[0].idx : 3'd0;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("busy", 32'(busy), 32'(ev));
        chk("out_data", out_data, ed);
        chk("out_idx", 32'(out_idx), 32'(ei));
        chk("out_last", 32'(out_last), 32'(ev && ei == 3'd7));
        chk("done", 32'(done), 32'(exp_done));
        chk("load_drop", 32'(load_drop), 32'(exp_drop));
    endtask

    // Called at a negedge: apply inputs, check, advance model and clock one cycle.
    task automatic cycle(input logic ld, input logic [255:0] d, input logic rdy);
        logic  xfer, fin, accept;
        word_t w;
        load      = ld;
        digest_i  = d;
        out_ready = rdy;
        #1;
        model_check();
        xfer = (q.size() > 0) && rdy;
        fin  = xfer && (q[0].idx == 3'd7);
        if (xfer) w = q.pop_front();
        accept = ld && (q.size() == 0);
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                w.data = d[255-32*k -: 32];
                w.idx  = 3'(k);
                q.push_back(w);
            end
        end
        @(posedge CLK);
        exp_done = fin;
        exp_drop = ld && !accept;
        @(negedge CLK);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic advance_to(input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && q[0].idx != target && n < budget) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk("advance_reached", 32'(q.size() > 0), 32'd1);
    endtask

    typedef struct {
        logic        ld;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  ei;
        logic        el;
        logic        edn;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int          stalled[8];
        logic        r;
        logic [255:0] rd;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'hba7816bf, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h8f01cfea, 3'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h414140de, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h5dae2223, 3'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'hb00361a3, 3'd4, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h96177a9c, 3'd5, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'hb410ff61, 3'd6, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'hf20015ad, 3'd7, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop", 32'(load_drop), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cycle(1'b0, '0, 1'b1);

        // Basic "abc" stream from the vector table
        for (int i = 0; i < 11; i++) begin
            #1;
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            chk("tbl_data", out_data, tbl[i].ed);
            chk("tbl_idx", 32'(out_idx), 32'(tbl[i].ei));
            chk("tbl_last", 32'(out_last), 32'(tbl[i].el));
            chk("tbl_done", 32'(done), 32'(tbl[i].edn));
            #1;
            cycle(tbl[i].ld, DIG_A, tbl[i].rdy);
            $display("table row %0d: data=%h idx=%0d last=%0b done=%0b", i, out_data, out_idx, out_last, done);
        end

        // Backpressure: two stall cycles each on idx 0, 3 and 7
        for (int k = 0; k < 8; k++) stalled[k] = 0;
        cycle(1'b1, DIG_A, 1'b1);
        for (int n = 0; n < 60 && q.size() > 0; n++) begin
            r = 1'b1;
            if ((q[0].idx == 3'd0 || q[0].idx == 3'd3 || q[0].idx == 3'd7) && stalled[q[0].idx] < 2) begin
                r = 1'b0;
                stalled[q[0].idx]++;
            end
            cycle(1'b0, '0, r);
        end
        chk("bp_drained", 32'(q.size()), 32'd0);
        cycle(1'b0, '0, 1'b1);
        $display("backpressure sequence complete");

        // Dropped load at idx 4
        cycle(1'b1, DIG_A, 1'b1);
        advance_to(3'd4, 20);
        cycle(1'b1, DIG_F, 1'b1);
        chk("drop_pulse", 32'(load_drop), 32'd1);
        chk("drop_next_word", out_data, 32'h96177a9c);
        drain(20);
        $display("dropped-load sequence complete");

        // Back-to-back digests
        cycle(1'b1, DIG_A, 1'b1);
        advance_to(3'd7, 20);
        cycle(1'b1, DIG_B, 1'b1);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_h0", out_data, 32'he3b0c442);
        chk("b2b_idx", 32'(out_idx), 32'd0);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        drain(20);
        $display("back-to-back sequence complete");

        // Asynchronous reset mid-stream at idx 2
        cycle(1'b1, DIG_A, 1'b1);
        advance_to(3'd2, 20);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        q.delete();
        exp_done = 1'b0;
        exp_drop = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, DIG_B, 1'b1);
        chk("post_rst_h0", out_data, 32'he3b0c442);
        chk("post_rst_idx", 32'(out_idx), 32'd0);
        drain(20);
        $display("mid-stream reset sequence complete");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 8; k++) rd[32*k +: 32] = $urandom;
            cycle($urandom_range(0, 5) == 0, rd, $urandom_range(0, 3) != 0);
        end
        drain(40);
        $display("random traffic complete");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
